gpio_reader: RTL

Memory-mapped input side of the 16-pin GPIO port: samples the pins, synchronises and optionally debounces them, latches rising and falling edges, and returns them to the CPU on register reads. It sits beside `gpiocon` on the same pins and bus. Pins that `gpiocon` has not yet switched to output mode float, and their external level is read here. Driven pins read back their driven value.

---
 rtl/gpio_reader.sv | 73 +++++++
 1 files changed

// File: rtl/gpio_reader.sv
// gpio_reader: GPIO input port with synchroniser, optional debounce (GPIO_DEBOUNCE_EN),
// sticky edge flags and registered, OR-muxable read data.
module gpio_reader #(
    parameter int PRESCALE = 1000,
    parameter int ADDR_W   = 24
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [15:0]       GPIO,
    input  logic              RE,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       DOUT,
    output logic              EVENT
);
    logic [15:0] s1_q, s2_q, level_q, level_d, rise_q, rise_d, fall_q, fall_d, dout_q, dout_d;
    logic        hit;
`ifdef GPIO_DEBOUNCE_EN
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0][2:0]  sh_q, sh_d;
    logic              tick;
    always_comb begin
        tick    = cnt_q == 16'(PRESCALE - 1);
        cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
        sh_d    = sh_q;
        level_d = level_q;
        for (int i = 0; i < 16; i++) begin
            sh_d[i]    = tick ? {sh_q[i][1:0], s2_q[i]} : sh_q[i];
            level_d[i] = !tick ? level_q[i] : (&sh_d[i]) ? 1'b1 : (|sh_d[i]) ? level_q[i] : 1'b0;
        end
    end
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sh_q  <= sh_d;
        end
    end
`else
    always_comb level_d = s2_q;
`endif
    // DOUT captures pre-clear flags at the same edge that clears them; a new edge wins over the clear
    always_comb begin
        hit    = RE && ((ADDR >> 4) == ADDR_W'(20'h8001e));
        dout_d = !hit ? 16'h0000 :
                 ADDR[3:0] == 4'd0 ? level_q :
                 ADDR[3:0] == 4'd1 ? rise_q :
                 ADDR[3:0] == 4'd2 ? fall_q :
                 ADDR[3:0] == 4'd3 ? s2_q : 16'h0000;
        rise_d = (rise_q & ~{16{hit && ADDR[3:0] == 4'd1}}) | (level_d & ~level_q);
        fall_d = (fall_q & ~{16{hit && ADDR[3:0] == 4'd2}}) | (~level_d & level_q);
    end
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            dout_q  <= '0;
        end else begin
            s1_q    <= GPIO;
            s2_q    <= s1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            dout_q  <= dout_d;
        end
    end
    assign DOUT  = dout_q;
    assign EVENT = |{rise_q, fall_q};
endmodule
